// File: rtl/bcd_counter_2digit.sv
// Two-digit BCD up/down counter with a tick prescaler, synchronous clear and
// parallel load; digits feed per-digit BCD-to-7-segment decoders directly.
module bcd_counter_2digit #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned MODULO   = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       wrap,
  output logic       load_err
);

  localparam int unsigned PC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(TICK_DIV - 1);
  localparam logic [3:0] MAX_T = 4'((MODULO - 1) / 10);
  localparam logic [3:0] MAX_O = 4'((MODULO - 1) % 10);

  logic [PC_W-1:0] pc;
  logic            step;
  logic [3:0]      ld_t, ld_o;
  logic [7:0]      ld_bin;
  logic            ld_ok;

  // Next state for an up step: {wrap, tens, ones}; carries are decimal, per nibble.
  function automatic logic [8:0] bcd_inc(input logic [3:0] t, input logic [3:0] o);
    if (t == MAX_T && o == MAX_O) return {1'b1, 4'd0, 4'd0};
    else if (o == 4'd9)           return {1'b0, t + 4'd1, 4'd0};
    else                          return {1'b0, t, o + 4'd1};
  endfunction

  function automatic logic [8:0] bcd_dec(input logic [3:0] t, input logic [3:0] o);
    if (t == 4'd0 && o == 4'd0) return {1'b1, MAX_T, MAX_O};
    else if (o == 4'd0)         return {1'b0, t - 4'd1, 4'd9};
    else                        return {1'b0, t, o - 4'd1};
  endfunction

  assign step   = en && (pc == PC_LAST);
  assign ld_t   = load_val[7:4];
  assign ld_o   = load_val[3:0];
  assign ld_bin = 8'(ld_t) * 8'd10 + 8'(ld_o);
  assign ld_ok  = (ld_t <= 4'd9) && (ld_o <= 4'd9) && (ld_bin < 8'(MODULO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= '0;
      ones     <= 4'd0;
      tens     <= 4'd0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
      if (clr) begin
        pc   <= '0;
        ones <= 4'd0;
        tens <= 4'd0;
      end else if (load) begin
        // A rejected load freezes pc for this cycle and swallows any step.
        if (ld_ok) begin
          tens <= ld_t;
          ones <= ld_o;
          pc   <= '0;
        end else begin
          load_err <= 1'b1;
        end
      end else if (step) begin
        pc <= '0;
        if (up) {wrap, tens, ones} <= bcd_inc(tens, ones);
        else    {wrap, tens, ones} <= bcd_dec(tens, ones);
      end else if (en) begin
        pc <= pc + PC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bcd_counter_2digit.sv
// Directed bench for bcd_counter_2digit: a MODULO=60 instance carries most
// scenarios, a MODULO=100 instance covers the 00 -> 99 down-wrap.
module tb_bcd_counter_2digit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0, up = 1'b1, clr = 1'b0, load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [3:0] ones, tens;
  logic       wrap, load_err;

  logic       en2 = 1'b0, up2 = 1'b0, clr2 = 1'b0, load2 = 1'b0;
  logic [7:0] load_val2 = 8'h00;
  logic [3:0] ones2, tens2;
  logic       wrap2, load_err2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  bcd_counter_2digit #(.TICK_DIV(4), .MODULO(60)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .ones(ones), .tens(tens), .wrap(wrap), .load_err(load_err)
  );

  bcd_counter_2digit #(.TICK_DIV(4), .MODULO(100)) dut100 (
    .clk(clk), .rst_n(rst_n), .en(en2), .up(up2), .clr(clr2), .load(load2),
    .load_val(load_val2), .ones(ones2), .tens(tens2), .wrap(wrap2), .load_err(load_err2)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic ticks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; load_val = v;
    ticks(1);
    load = 1'b0;
  endtask

  initial begin
    // Reset and first steps
    #2 rst_n = 1'b0;
    ticks(3);
    chk("reset_digits", {tens, ones}, 8'h00);
    chk("reset_flags", {6'd0, wrap, load_err}, 8'h00);
    rst_n = 1'b1; en = 1'b1; up = 1'b1;
    ticks(3);
    chk("pre_first_step", {tens, ones}, 8'h00);
    ticks(1);
    chk("first_step", {tens, ones}, 8'h01);
    ticks(4);
    chk("second_step", {tens, ones}, 8'h02);
    ticks(32);
    chk("carry_9_to_10", {tens, ones}, 8'h10);

    // Up wrap 59 -> 00
    do_load(8'h59);
    chk("load_59", {tens, ones}, 8'h59);
    ticks(3);
    chk("hold_59", {tens, ones}, 8'h59);
    ticks(1);
    chk("up_wrap_digits", {tens, ones}, 8'h00);
    chk("up_wrap_pulse", {7'd0, wrap}, 8'h01);
    ticks(1);
    chk("wrap_one_cycle", {7'd0, wrap}, 8'h00);
    ticks(3);
    chk("after_wrap", {tens, ones}, 8'h01);
    chk("after_wrap_nowrap", {7'd0, wrap}, 8'h00);

    // Down borrow and wrap 00 -> 59
    up = 1'b0;
    do_load(8'h10);
    chk("load_10", {tens, ones}, 8'h10);
    ticks(4);
    chk("borrow_10_09", {tens, ones}, 8'h09);
    for (int k = 8; k >= 0; k--) begin
      ticks(4);
      chk("down_step", {tens, ones}, {4'd0, 4'(k)});
    end
    ticks(4);
    chk("down_wrap_digits", {tens, ones}, 8'h59);
    chk("down_wrap_pulse", {7'd0, wrap}, 8'h01);
    ticks(1);
    chk("down_wrap_clear", {7'd0, wrap}, 8'h00);

    // Invalid loads at pc=1: digits and pc hold
    up = 1'b1;
    do_load(8'h60);
    chk("bad60_err", {7'd0, load_err}, 8'h01);
    chk("bad60_digits", {tens, ones}, 8'h59);
    do_load(8'h1A);
    chk("bad1A_err", {7'd0, load_err}, 8'h01);
    chk("bad1A_digits", {tens, ones}, 8'h59);
    ticks(1);
    chk("err_one_cycle", {7'd0, load_err}, 8'h00);
    ticks(1);
    chk("pc_held_no_step", {tens, ones}, 8'h59);
    ticks(1);
    chk("step_after_bad_loads", {tens, ones}, 8'h00);
    do_load(8'h42);
    chk("load_42", {tens, ones}, 8'h42);
    chk("load_42_noerr", {7'd0, load_err}, 8'h00);

    // clr beats load
    clr = 1'b1;
    do_load(8'h33);
    clr = 1'b0;
    chk("clr_over_load", {tens, ones}, 8'h00);
    chk("clr_over_load_noerr", {7'd0, load_err}, 8'h00);

    // Load coincident with step
    ticks(3);
    do_load(8'h25);
    chk("load_beats_step", {tens, ones}, 8'h25);
    ticks(3);
    chk("pc_restarted", {tens, ones}, 8'h25);
    ticks(1);
    chk("step_after_load", {tens, ones}, 8'h26);

    // en=0 hold mid-prescale
    ticks(2);
    en = 1'b0;
    ticks(10);
    chk("en0_hold", {tens, ones}, 8'h26);
    en = 1'b1;
    ticks(1);
    chk("resume_pc3", {tens, ones}, 8'h26);
    ticks(1);
    chk("resume_step", {tens, ones}, 8'h27);

    // Async reset between edges
    do_load(8'h37);
    chk("load_37", {tens, ones}, 8'h37);
    ticks(1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_digits", {tens, ones}, 8'h00);
    ticks(1);
    rst_n = 1'b1;
    do_load(8'h59);
    ticks(4);
    chk("wrap_before_rst", {7'd0, wrap}, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_wrap", {6'd0, wrap, load_err}, 8'h00);
    chk("async_rst_digits2", {tens, ones}, 8'h00);
    ticks(1);
    rst_n = 1'b1;

    // MODULO=100 down-wrap
    en = 1'b0;
    en2 = 1'b1;
    ticks(3);
    chk("m100_before", {tens2, ones2}, 8'h00);
    ticks(1);
    chk("m100_down_wrap", {tens2, ones2}, 8'h99);
    chk("m100_wrap_pulse", {7'd0, wrap2}, 8'h01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
